// File: rtl/serial_add_pkg.sv
// +------------------------------------------------------------------+
// | serial_add_pkg : shared FSM encoding and default width            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_fa.sv
// +------------------------------------------------------------------+
// | fa : 1-bit full adder, the bit-slice of the serial adder          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module fa (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// +------------------------------------------------------------------+
// | serial_add_ctrl : bit-serial adder, one fa sequenced WIDTH cycles |
// | Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow output  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             fa_s;
    logic             fa_co;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    fa u_fa (
        .s  (fa_s),
        .co (fa_co),
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                s_sh_d  = {fa_s, s_sh_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                // Last bit: publish the completed sum on the DONE-entry edge
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    s_d     = s_sh_d;
                    co_d    = fa_co;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ fa_co;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign s    = s_q;
    assign co   = co_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// +------------------------------------------------------------------+
// | tb_serial_add_ctrl : self-checking bench for serial_add_ctrl      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ci      (ci),
        .busy    (busy),
        .done    (done),
        .s       (s),
        .co      (co)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-precision unsigned sum
    function automatic int ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return int'(x) + int'(y) + int'(c);
    endfunction

    // Reference: two's-complement result out of W-bit signed range
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int sx, sy, t;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        t  = sx + sy + int'(c);
        return (t > (1 << (W-1)) - 1) || (t < -(1 << (W-1)));
    endfunction

    // Issues one add from idle and waits (bounded) for done.
    task automatic run_add(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic cii,
                           output logic [W-1:0] so, output logic coo, output logic ovfo,
                           output int lato, output int busyo, output bit holdo);
        logic [W-1:0] s_prev;
        logic         co_prev;
        @(negedge clk);
        a = ai; b = bi; ci = cii; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        s_prev = s; co_prev = co;
        lato = 0; busyo = 0; holdo = 1'b1;
        for (int k = 0; k < 4 * W; k++) begin
            @(negedge clk);
            lato++;
            if (busy) busyo++;
            if (busy && done) holdo = 1'b0;
            if (done) break;
            if (s !== s_prev || co !== co_prev) holdo = 1'b0;
        end
        so = s; coo = co;
`ifdef SERIAL_ADD_OVF_EN
        ovfo = ovf;
`else
        ovfo = 1'b0;
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        #12;
        n_vec++;
        if ({busy, done, co, s} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b co=%b s=%h, expected all 0", busy, done, co, s);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] so; logic coo, ovfo; int lat, bc; bit hold;
        run_add(4'h3, 4'h5, 1'b0, so, coo, ovfo, lat, bc, hold);
        n_vec++;
        if ({coo, so} !== 5'h08) begin
            n_err++;
            $display("FAIL basic_sum: got co=%b s=%h, expected co=0 s=8", coo, so);
        end
        n_vec++;
        if (lat !== W + 1) begin
            n_err++;
            $display("FAIL basic_latency: got %0d, expected %0d", lat, W + 1);
        end
        n_vec++;
        if (bc !== W) begin
            n_err++;
            $display("FAIL basic_busy_cycles: got %0d, expected %0d", bc, W);
        end
        n_vec++;
        if (hold !== 1'b1) begin
            n_err++;
            $display("FAIL basic_hold: got %b, expected 1 (s/co stable, busy&done exclusive)", hold);
        end
    endtask

    task automatic test_carry();
        logic [W-1:0] so; logic coo, ovfo; int lat, bc; bit hold;
        run_add(4'hF, 4'h1, 1'b0, so, coo, ovfo, lat, bc, hold);
        n_vec++;
        if ({coo, so} !== 5'h10) begin
            n_err++;
            $display("FAIL carry_f_plus_1: got co=%b s=%h, expected co=1 s=0", coo, so);
        end
        run_add(4'hF, 4'hF, 1'b1, so, coo, ovfo, lat, bc, hold);
        n_vec++;
        if ({coo, so} !== 5'h1F) begin
            n_err++;
            $display("FAIL carry_f_f_ci: got co=%b s=%h, expected co=1 s=f", coo, so);
        end
    endtask

    task automatic test_sweep();
        logic [W-1:0] so, ai, bi; logic coo, ovfo, cii; int lat, bc; bit hold;
        for (int i = 0; i < 512; i++) begin
            ai  = i[3:0];
            bi  = i[7:4];
            cii = i[8];
            run_add(ai, bi, cii, so, coo, ovfo, lat, bc, hold);
            n_vec++;
            if (int'({coo, so}) !== ref_sum(ai, bi, cii) || lat !== W + 1) begin
                n_err++;
                $display("FAIL sweep a=%h b=%h ci=%b: got %0d lat %0d, expected %0d lat %0d",
                         ai, bi, cii, int'({coo, so}), lat, ref_sum(ai, bi, cii), W + 1);
            end
        end
    endtask

    task automatic test_ignore_start();
        int n_done; logic [W-1:0] s_at_done; logic co_at_done;
        @(negedge clk);
        a = 4'h3; b = 4'h5; ci = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 4'h9; b = 4'h6; ci = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_done = 0; s_at_done = '0; co_at_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                s_at_done = s; co_at_done = co;
            end
        end
        n_vec++;
        if (n_done !== 1) begin
            n_err++;
            $display("FAIL ignore_start_done_count: got %0d, expected 1", n_done);
        end
        n_vec++;
        if ({co_at_done, s_at_done} !== 5'h08) begin
            n_err++;
            $display("FAIL ignore_start_sum: got co=%b s=%h, expected co=0 s=8", co_at_done, s_at_done);
        end
    endtask

    task automatic test_back_to_back();
        int gap; bit seen;
        @(negedge clk);
        a = 4'h3; b = 4'h4; ci = 1'b0; start = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4 * W; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (seen !== 1'b1 || {co, s} !== 5'h07) begin
            n_err++;
            $display("FAIL b2b_first: got seen=%b co=%b s=%h, expected seen=1 co=0 s=7", seen, co, s);
        end
        a = 4'h2; b = 4'h2; ci = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        gap = 0;
        for (int k = 0; k < 4 * W; k++) begin
            @(negedge clk);
            gap++;
            if (done) break;
        end
        n_vec++;
        if (gap !== W + 1) begin
            n_err++;
            $display("FAIL b2b_gap: got %0d cycles between dones, expected %0d", gap, W + 1);
        end
        n_vec++;
        if ({co, s} !== 5'h04) begin
            n_err++;
            $display("FAIL b2b_second: got co=%b s=%h, expected co=0 s=4", co, s);
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] so; logic coo, ovfo; int lat, bc; bit hold; bit quiet;
        run_add(4'hF, 4'hF, 1'b1, so, coo, ovfo, lat, bc, hold);
        @(negedge clk);
        a = 4'h1; b = 4'h2; ci = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, co, s} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got busy=%b done=%b co=%b s=%h, expected all 0", busy, done, co, s);
        end
        @(negedge clk);
        reset_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy || done) quiet = 1'b0;
        end
        n_vec++;
        if (quiet !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset_idle: got activity after release, expected idle");
        end
        run_add(4'h6, 4'h7, 1'b0, so, coo, ovfo, lat, bc, hold);
        n_vec++;
        if ({coo, so} !== 5'h0D || lat !== W + 1) begin
            n_err++;
            $display("FAIL async_reset_recover: got co=%b s=%h lat %0d, expected co=0 s=d lat %0d",
                     coo, so, lat, W + 1);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] so, ai, bi; logic coo, ovfo, cii; int lat, bc; bit hold;
        for (int i = 0; i < 150; i++) begin
            ai  = W'($urandom);
            bi  = W'($urandom);
            cii = 1'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(negedge clk);
            run_add(ai, bi, cii, so, coo, ovfo, lat, bc, hold);
            n_vec++;
            if (int'({coo, so}) !== ref_sum(ai, bi, cii) || bc !== W || hold !== 1'b1) begin
                n_err++;
                $display("FAIL random a=%h b=%h ci=%b: got %0d busy %0d hold %b, expected %0d busy %0d hold 1",
                         ai, bi, cii, int'({coo, so}), bc, hold, ref_sum(ai, bi, cii), W);
            end
`ifdef SERIAL_ADD_OVF_EN
            n_vec++;
            if (ovfo !== ref_ovf(ai, bi, cii)) begin
                n_err++;
                $display("FAIL random_ovf a=%h b=%h ci=%b: got %b, expected %b",
                         ai, bi, cii, ovfo, ref_ovf(ai, bi, cii));
            end
`endif
        end
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] so; logic coo, ovfo; int lat, bc; bit hold;
        run_add(4'h7, 4'h1, 1'b0, so, coo, ovfo, lat, bc, hold);
        n_vec++;
        if (ovfo !== 1'b1 || {coo, so} !== 5'h08) begin
            n_err++;
            $display("FAIL ovf_7_1: got ovf=%b co=%b s=%h, expected ovf=1 co=0 s=8", ovfo, coo, so);
        end
        run_add(4'hF, 4'h1, 1'b0, so, coo, ovfo, lat, bc, hold);
        n_vec++;
        if (ovfo !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_f_1: got ovf=%b, expected 0", ovfo);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_sweep();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_random();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
